// File: rtl/channel_serializer.sv
// channel_serializer: captures one frame of NCH parallel channel words and
// streams them out one word per beat, channel 0 first, over a valid/ready
// serial interface. A new frame can be taken on the last-beat transfer, so
// frames can follow each other with no idle cycle between them.
module channel_serializer #(
  parameter int  WIDTH = 21,
  parameter int  NCH   = 32,
  localparam int CNT_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 srdyi,
  input  logic [NCH*WIDTH-1:0] in_bus,
  output logic                 drdyo,
  output logic                 srdyo,
  input  logic                 drdyi,
  output logic [WIDTH-1:0]     dout,
  output logic [CNT_W-1:0]     chan,
  output logic                 eof
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] shadow [NCH];
  logic             last_beat;
  logic             accept;
  logic             xfer;

  // Serial-side outputs come from registered state only; drdyo is the one
  // output that also looks at an input (drdyi), enabling back-to-back frames.
  assign last_beat = (cnt_reg == CNT_W'(NCH - 1));
  assign srdyo     = (state_reg == SEND);
  assign eof       = srdyo & last_beat;
  assign chan      = cnt_reg;
  assign dout      = srdyo ? shadow[cnt_reg] : '0;
  assign drdyo     = (state_reg == IDLE) | (eof & drdyi);
  assign accept    = srdyi & drdyo;
  assign xfer      = srdyo & drdyi;

  // Per-channel shadow registers: the whole frame is captured on acceptance
  // so upstream may change in_bus immediately afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : gen_shadow
      logic [WIDTH-1:0] word_reg;

      // Load channel gi's word on frame acceptance; clear on reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= '0;
        end else if (accept) begin
          word_reg <= in_bus[gi*WIDTH +: WIDTH];
        end
      end

      assign shadow[gi] = word_reg;
    end
  endgenerate

  // State and beat counter register; reset overrides any accept/transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: advance on each transfer, end or restart the frame on
  // the last beat depending on whether a new frame is accepted alongside it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          cnt_next   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_beat) begin
            cnt_next   = '0;
            state_next = accept ? SEND : IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_channel_serializer.sv
// Self-checking bench for channel_serializer. A negedge monitor keeps a
// scoreboard of expected beats (pushed when a frame is accepted, popped on
// each transfer); scenario tasks add targeted inline checks.
module tb_channel_serializer;
  localparam int WIDTH = 21;
  localparam int NCH   = 32;
  localparam int CNT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] chan;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 srdyi = 1'b0;
  logic [NCH*WIDTH-1:0] in_bus = '0;
  logic                 drdyo;
  logic                 srdyo;
  logic                 drdyi = 1'b1;
  logic [WIDTH-1:0]     dout;
  logic [CNT_W-1:0]     chan;
  logic                 eof;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];

  channel_serializer #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .srdyi (srdyi),
    .in_bus(in_bus),
    .drdyo (drdyo),
    .srdyo (srdyo),
    .drdyi (drdyi),
    .dout  (dout),
    .chan  (chan),
    .eof   (eof)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compares outputs on the falling edge, then applies
  // the transfer (pop) and accept (push) that the next rising edge performs.
  always @(negedge clk) begin
    if (mon_en) begin
      logic  exp_srdyo;
      logic  exp_drdyo;
      beat_t b;
      exp_srdyo = (exp_q.size() != 0);
      exp_drdyo = (exp_q.size() == 0) ||
                  (exp_q.size() == 1 && exp_q[0].chan == CNT_W'(NCH - 1) && drdyi);
      checks++;
      if (srdyo !== exp_srdyo) begin
        errors++;
        $display("FAIL mon_srdyo: got %b expected %b", srdyo, exp_srdyo);
      end
      checks++;
      if (drdyo !== exp_drdyo) begin
        errors++;
        $display("FAIL mon_drdyo: got %b expected %b", drdyo, exp_drdyo);
      end
      if (exp_srdyo) begin
        b = exp_q[0];
        checks++;
        if (dout !== b.data || chan !== b.chan ||
            eof !== (b.chan == CNT_W'(NCH - 1))) begin
          errors++;
          $display("FAIL mon_beat: got dout=%0d chan=%0d eof=%b expected dout=%0d chan=%0d eof=%b",
                   dout, chan, eof, b.data, b.chan, (b.chan == CNT_W'(NCH - 1)));
        end
      end else begin
        checks++;
        if (dout !== '0 || eof !== 1'b0) begin
          errors++;
          $display("FAIL mon_idle: got dout=%0d eof=%b expected dout=0 eof=0", dout, eof);
        end
      end
      if (reset) begin
        exp_q.delete();
      end else begin
        if (exp_srdyo && drdyi) begin
          b = exp_q.pop_front();
          $display("beat: chan=%0d dout=%0d eof=%b", b.chan, b.data, (b.chan == CNT_W'(NCH - 1)));
        end
        if (srdyi && exp_drdyo) begin
          for (int k = 0; k < NCH; k++) begin
            b.data = in_bus[k*WIDTH +: WIDTH];
            b.chan = CNT_W'(k);
            exp_q.push_back(b);
          end
          $display("frame accepted: word0=%0d", in_bus[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus_inc(input int base);
    for (int k = 0; k < NCH; k++) in_bus[k*WIDTH +: WIDTH] = WIDTH'(base + k);
  endtask

  task automatic set_bus_const(input int v);
    for (int k = 0; k < NCH; k++) in_bus[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: %0d beats still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_chan(input int target, input int budget);
    int n = 0;
    while (!(srdyo === 1'b1 && chan === CNT_W'(target)) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(srdyo === 1'b1 && chan === CNT_W'(target))) begin
      errors++;
      $display("FAIL wait_chan: chan=%0d srdyo=%b expected chan %0d", chan, srdyo, target);
    end
  endtask

  // Accept one frame with base+k words in one cycle.
  task automatic send_frame(input int base);
    set_bus_inc(base);
    srdyi = 1'b1;
    tick();
    srdyi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (srdyo !== 1'b0 || dout !== '0 || chan !== '0 || eof !== 1'b0 || drdyo !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: srdyo=%b dout=%0d chan=%0d eof=%b drdyo=%b expected 0 0 0 0 1",
               srdyo, dout, chan, eof, drdyo);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    drdyi = 1'b1;
    send_frame(1);
    checks++;
    if (drdyo !== 1'b0 || srdyo !== 1'b1 || dout !== 21'd1) begin
      errors++;
      $display("FAIL basic_first: drdyo=%b srdyo=%b dout=%0d expected 0 1 1", drdyo, srdyo, dout);
    end
    wait_idle(100);
    checks++;
    if (drdyo !== 1'b1 || srdyo !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: drdyo=%b srdyo=%b expected 1 0", drdyo, srdyo);
    end
  endtask

  task automatic test_stall();
    drdyi = 1'b1;
    send_frame(1);
    wait_chan(5, 50);
    drdyi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dout !== 21'd6 || chan !== 5'd5 || srdyo !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: dout=%0d chan=%0d srdyo=%b expected 6 5 1", dout, chan, srdyo);
      end
    end
    drdyi = 1'b1;
    wait_idle(100);
  endtask

  task automatic test_back_to_back();
    bit acc = 1'b0;
    bit seen31;
    int n = 0;
    drdyi = 1'b1;
    send_frame(1);
    set_bus_inc(100);
    srdyi = 1'b1;
    while (!acc && n < 100) begin
      seen31 = (srdyo === 1'b1 && chan === 5'd31);
      acc = (drdyo === 1'b1);
      tick();
      n++;
      if (seen31) begin
        checks++;
        if (srdyo !== 1'b1 || dout !== 21'd100 || chan !== 5'd0) begin
          errors++;
          $display("FAIL b2b_gap: srdyo=%b dout=%0d chan=%0d expected 1 100 0", srdyo, dout, chan);
        end
      end
    end
    srdyi = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL b2b_accept: frame B not accepted within %0d cycles", n);
    end
    wait_idle(100);
  endtask

  task automatic test_ignore();
    drdyi = 1'b1;
    send_frame(1);
    wait_chan(12, 50);
    set_bus_const(7);
    srdyi = 1'b1;
    #1;
    checks++;
    if (drdyo !== 1'b0) begin
      errors++;
      $display("FAIL ignore_drdyo: got %b expected 0", drdyo);
    end
    tick();
    srdyi = 1'b0;
    set_bus_inc(1);
    wait_idle(100);
  endtask

  task automatic test_bus_change();
    drdyi = 1'b1;
    send_frame(1);
    set_bus_const(0);
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    drdyi = 1'b1;
    send_frame(1);
    wait_chan(10, 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (srdyo !== 1'b0 || dout !== '0 || drdyo !== 1'b1 || chan !== '0 || eof !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: srdyo=%b dout=%0d drdyo=%b chan=%0d eof=%b expected 0 0 1 0 0",
               srdyo, dout, drdyo, chan, eof);
    end
    send_frame(200);
    checks++;
    if (dout !== 21'd200 || chan !== '0) begin
      errors++;
      $display("FAIL reset_restart: dout=%0d chan=%0d expected 200 0", dout, chan);
    end
    wait_idle(100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_ignore();
    test_bus_change();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
